// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini-SRC hardwired controller: opcodes,
// ALU operation codes, controller states and instruction classes.
package control_unit_pkg;

    // Instruction opcodes (irOut[31:27])
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation codes used when the controller picks the operation itself
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    // Controller states
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    // One-hot instruction class bit positions
    localparam int CLS_RTYPE = 0;
    localparam int CLS_UNARY = 1;
    localparam int CLS_IMM   = 2;
    localparam int CLS_LDI   = 3;
    localparam int CLS_LD    = 4;
    localparam int CLS_ST    = 5;
    localparam int CLS_BR    = 6;
    localparam int CLS_JR    = 7;
    localparam int CLS_JAL   = 8;
    localparam int CLS_NOP   = 9;
    localparam int CLS_HALT  = 10;
    localparam int NUM_CLS   = 11;

    typedef logic [NUM_CLS-1:0] op_class_t;

    // ALU operation for the immediate forms (addi/andi/ori)
    function automatic logic [4:0] imm_alu_op(input logic [4:0] opcode);
        case (opcode)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            default: imm_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_opcode_classifier.sv
// Maps a 5-bit opcode to a one-hot instruction class. Anything not
// recognised is treated as a nop.
module opcode_classifier
    import control_unit_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    // Combinational opcode-to-class decode
    always_comb begin
        op_class = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  op_class[CLS_RTYPE] = 1'b1;
            OP_NEG, OP_NOT:                   op_class[CLS_UNARY] = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:         op_class[CLS_IMM]   = 1'b1;
            OP_LDI:                           op_class[CLS_LDI]   = 1'b1;
            OP_LD:                            op_class[CLS_LD]    = 1'b1;
            OP_ST:                            op_class[CLS_ST]    = 1'b1;
            OP_BR:                            op_class[CLS_BR]    = 1'b1;
            OP_JR:                            op_class[CLS_JR]    = 1'b1;
            OP_JAL:                           op_class[CLS_JAL]   = 1'b1;
            OP_HALT:                          op_class[CLS_HALT]  = 1'b1;
            default:                          op_class[CLS_NOP]   = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle controller for the Mini-SRC datapath. A registered
// T0..T7 step counter walks fetch/decode/execute; every strobe is a
// combinational decode of (state, instruction class), so an asynchronous
// reset drops all strobes in the same cycle.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] irOut,
    input  logic        CONout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        CONin,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  aluOp,
    output logic        run
);

    state_t     state_reg;
    state_t     state_next;
    op_class_t  op_class;
    logic [4:0] opcode;
    logic       ir_unused;

    assign opcode    = irOut[31:27];
    // Register fields are decoded by select_and_encode, not here
    assign ir_unused = ^irOut[26:0];

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // State register; reset forces RST immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_RST;
        else       state_reg <= state_next;
    end

    // Step sequencing: each class returns to T0 after its last step
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RST:  state_next = ST_T0;
            ST_T0:   state_next = ST_T1;
            ST_T1:   state_next = ST_T2;
            ST_T2:   state_next = ST_T3;
            ST_T3: begin
                if (op_class[CLS_HALT])                         state_next = ST_HALT;
                else if (op_class[CLS_JR] || op_class[CLS_NOP]) state_next = ST_T0;
                else                                            state_next = ST_T4;
            end
            ST_T4:   state_next = (op_class[CLS_UNARY] || op_class[CLS_JAL]) ? ST_T0 : ST_T5;
            ST_T5:   state_next = (op_class[CLS_LD] || op_class[CLS_ST] || op_class[CLS_BR])
                                  ? ST_T6 : ST_T0;
            ST_T6:   state_next = op_class[CLS_BR] ? ST_T0 : ST_T7;
            ST_T7:   state_next = ST_T0;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase
    end

    // Strobe decode from current step and instruction class
    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0; PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; Zlowout = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
        aluOp = 5'b00000;
        run = (state_reg != ST_RST) && (state_reg != ST_HALT);
        case (state_reg)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                if (op_class[CLS_RTYPE] || op_class[CLS_IMM]) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (op_class[CLS_UNARY]) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; aluOp = opcode;
                end else if (op_class[CLS_LDI] || op_class[CLS_LD] || op_class[CLS_ST]) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (op_class[CLS_BR]) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (op_class[CLS_JR]) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (op_class[CLS_JAL]) begin
                    PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
                end
            end
            ST_T4: begin
                if (op_class[CLS_RTYPE]) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; aluOp = opcode;
                end else if (op_class[CLS_UNARY]) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_class[CLS_IMM]) begin
                    Cout = 1'b1; Zin = 1'b1; aluOp = imm_alu_op(opcode);
                end else if (op_class[CLS_LDI] || op_class[CLS_LD] || op_class[CLS_ST]) begin
                    Cout = 1'b1; Zin = 1'b1; aluOp = ALU_ADD;
                end else if (op_class[CLS_BR]) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (op_class[CLS_JAL]) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
            end
            ST_T5: begin
                if (op_class[CLS_RTYPE] || op_class[CLS_IMM] || op_class[CLS_LDI]) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_class[CLS_LD] || op_class[CLS_ST]) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (op_class[CLS_BR]) begin
                    Cout = 1'b1; Zin = 1'b1; aluOp = ALU_ADD;
                end
            end
            ST_T6: begin
                if (op_class[CLS_LD]) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (op_class[CLS_ST]) begin
                    // MDR loads from the bus because Read stays low
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (op_class[CLS_BR] && CONout) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            ST_T7: begin
                if (op_class[CLS_LD]) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_class[CLS_ST]) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
